// File: rtl/predecode_aligner_if.sv
// Handshake bus for predecode_aligner: I_CACHE bundle in, aligned/pre-decoded bundle out.
interface predecode_aligner_if #(
    parameter int ADDRESS_WIDTH = 22,
    parameter int DATA_WIDTH    = 32,
    parameter int FETCH_WIDTH   = 4,
    parameter int OFS_W         = $clog2(FETCH_WIDTH)
);
    logic                              i_valid;
    logic                              o_ready;
    logic [ADDRESS_WIDTH-1:0]          i_pc;
    logic [FETCH_WIDTH*DATA_WIDTH-1:0] i_bundle;
    logic                              i_flush;
    logic                              o_valid;
    logic                              i_ready;
    logic [FETCH_WIDTH*DATA_WIDTH-1:0] o_insts;
    logic [FETCH_WIDTH-1:0]            o_lane_valid;
    logic [ADDRESS_WIDTH-1:0]          o_pc;
    logic                              o_cf_found;
    logic [OFS_W-1:0]                  o_cf_lane;
    logic                              o_isbranch;
    logic                              o_j_inst;
    logic                              o_jal_inst;
    logic                              o_jr_inst;
    logic [ADDRESS_WIDTH-1:0]          o_branch_address;
    logic [ADDRESS_WIDTH-1:0]          o_Branch_Target;
    logic                              o_delay_slot;
    logic                              o_ds_head;

    modport slave (
        input  i_valid, i_pc, i_bundle, i_flush, i_ready,
        output o_ready, o_valid, o_insts, o_lane_valid, o_pc, o_cf_found, o_cf_lane,
               o_isbranch, o_j_inst, o_jal_inst, o_jr_inst, o_branch_address,
               o_Branch_Target, o_delay_slot, o_ds_head
    );

    modport master (
        output i_valid, i_pc, i_bundle, i_flush, i_ready,
        input  o_ready, o_valid, o_insts, o_lane_valid, o_pc, o_cf_found, o_cf_lane,
               o_isbranch, o_j_inst, o_jal_inst, o_jr_inst, o_branch_address,
               o_Branch_Target, o_delay_slot, o_ds_head
    );
endinterface

// File: rtl/predecode_aligner.sv
// Fetch pre-decode/align stage with 2-entry output skid FIFO.
// Define PREDECODE_JALR_EN to treat jalr as a control-flow instruction (indirect + link).
module predecode_aligner #(
    parameter int ADDRESS_WIDTH = 22,
    parameter int DATA_WIDTH    = 32,
    parameter int FETCH_WIDTH   = 4
) (
    input logic                i_clk,
    input logic                i_rst_n,
    predecode_aligner_if.slave bus
);
    localparam int AW    = ADDRESS_WIDTH;
    localparam int DW    = DATA_WIDTH;
    localparam int FW    = FETCH_WIDTH;
    localparam int OFS_W = $clog2(FETCH_WIDTH);

    typedef struct packed {
        logic [FW*DW-1:0] insts;
        logic [FW-1:0]    lane_valid;
        logic [AW-1:0]    pc;
        logic             cf_found;
        logic [OFS_W-1:0] cf_lane;
        logic             isbranch;
        logic             j_inst;
        logic             jal_inst;
        logic             jr_inst;
        logic [AW-1:0]    branch_address;
        logic [AW-1:0]    target;
        logic             delay_slot;
        logic             ds_head;
    } entry_t;

    // Returns {branch, j, jal, jr}; jalr raises jal and jr together.
    function automatic logic [3:0] classify(input logic [31:0] inst);
        logic [3:0] c;
        c = '0;
        case (inst[31:26])
            6'b000001, 6'b000100, 6'b000101, 6'b000110, 6'b000111: c[3] = 1'b1;
            6'b000010: c[2] = 1'b1;
            6'b000011: c[1] = 1'b1;
            6'b000000: begin
                if (inst[5:0] == 6'b001000) c[0] = 1'b1;
`ifdef PREDECODE_JALR_EN
                if (inst[5:0] == 6'b001001) c[1:0] = 2'b11;
`endif
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    entry_t [1:0]     mem_q, mem_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             ds_pend_q, ds_pend_d;

    logic [OFS_W-1:0] ofs, last, src, cf_lane;
    logic [DW-1:0]    al [FW];
    logic [3:0]       cls [FW];
    logic [FW-1:0]    lane_ok;
    logic             cf_found;
    logic [3:0]       cf_cls;
    logic [25:0]      cf_low;
    logic             push, pop, ready, valid;
    entry_t           new_e, head;

    always_comb begin
        ofs      = bus.i_pc[OFS_W-1:0];
        last     = OFS_W'(FW - 1) - ofs;
        src      = '0;
        cf_found = 1'b0;
        cf_lane  = '0;
        new_e    = '0;
        for (int unsigned k = 0; k < FW; k++) begin
            src        = OFS_W'(k) + ofs;
            al[k]      = bus.i_bundle[src*DW +: DW];
            lane_ok[k] = (OFS_W'(k) <= last);
            cls[k]     = lane_ok[k] ? classify(al[k]) : 4'b0000;
        end
        // Lane 0 is a pending delay slot when ds_pend is set, so it never starts a scan.
        for (int unsigned k = 0; k < FW; k++) begin
            if (!cf_found && cls[k] != 4'b0000 && !(ds_pend_q && k == 0)) begin
                cf_found = 1'b1;
                cf_lane  = OFS_W'(k);
            end
        end
        cf_cls = cf_found ? cls[cf_lane] : 4'b0000;
        cf_low = al[cf_lane][25:0];
        for (int unsigned k = 0; k < FW; k++) begin
            if (lane_ok[k] && (!cf_found || k <= 32'(cf_lane) + 1)) begin
                new_e.lane_valid[k]      = 1'b1;
                new_e.insts[k*DW +: DW]  = al[k];
            end
        end
        new_e.pc             = bus.i_pc;
        new_e.cf_found       = cf_found;
        new_e.cf_lane        = cf_lane;
        {new_e.isbranch, new_e.j_inst, new_e.jal_inst, new_e.jr_inst} = cf_cls;
        new_e.branch_address = bus.i_pc + AW'(cf_lane);
        if (cf_cls[0])
            new_e.target = '0;
        else if (cf_cls[3])
            new_e.target = AW'(32'(new_e.branch_address) + 32'd1
                               + 32'(signed'(cf_low[15:0])));
        else if (cf_cls[2] || cf_cls[1])
            new_e.target = AW'(cf_low);
        new_e.delay_slot = cf_found && (cf_lane == last);
        new_e.ds_head    = ds_pend_q;
    end

    assign ready = (count_q != 2'd2);
    assign valid = (count_q != 2'd0);
    assign push  = bus.i_valid && ready && !bus.i_flush;
    assign pop   = valid && bus.i_ready;

    always_comb begin
        mem_d     = mem_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        ds_pend_d = ds_pend_q;
        if (bus.i_flush) begin
            rd_ptr_d  = 1'b0;
            wr_ptr_d  = 1'b0;
            count_d   = '0;
            ds_pend_d = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = new_e;
                wr_ptr_d        = ~wr_ptr_q;
                ds_pend_d       = new_e.delay_slot;
            end
            if (pop) rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mem_q     <= '0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= '0;
            ds_pend_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            ds_pend_q <= ds_pend_d;
        end
    end

    assign head                 = valid ? mem_q[rd_ptr_q] : '0;
    assign bus.o_ready          = ready;
    assign bus.o_valid          = valid;
    assign bus.o_insts          = head.insts;
    assign bus.o_lane_valid     = head.lane_valid;
    assign bus.o_pc             = head.pc;
    assign bus.o_cf_found       = head.cf_found;
    assign bus.o_cf_lane        = head.cf_lane;
    assign bus.o_isbranch       = head.isbranch;
    assign bus.o_j_inst         = head.j_inst;
    assign bus.o_jal_inst       = head.jal_inst;
    assign bus.o_jr_inst        = head.jr_inst;
    assign bus.o_branch_address = head.branch_address;
    assign bus.o_Branch_Target  = head.target;
    assign bus.o_delay_slot     = head.delay_slot;
    assign bus.o_ds_head        = head.ds_head;
endmodule

// File: tb/tb_predecode_aligner.sv
// Self-checking bench for predecode_aligner: directed vector table, corner sequences, random vs model.
module tb_predecode_aligner;
    localparam int AW = 22;
    localparam int DW = 32;
    localparam int FW = 4;
`ifdef PREDECODE_JALR_EN
    localparam bit JALR_EN = 1'b1;
`else
    localparam bit JALR_EN = 1'b0;
`endif
    localparam logic [31:0] NOP = 32'h20010001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    predecode_aligner_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .FETCH_WIDTH(FW)) bus ();
    predecode_aligner #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .FETCH_WIDTH(FW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [127:0] insts;
        logic [3:0]   lv;
        logic [21:0]  pc;
        logic         found;
        logic [1:0]   lane;
        logic [3:0]   cls;   // {branch, j, jal, jr}
        logic [21:0]  baddr;
        logic [21:0]  tgt;
        logic         ds;
        logic         dsh;
    } exp_t;

    typedef struct {
        logic [21:0]  pc;
        logic [127:0] bundle;
        exp_t         e;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_head(input string tag, input exp_t e);
        check({tag, "/valid"}, 128'(bus.o_valid), 128'd1);
        check({tag, "/insts"}, bus.o_insts, e.insts);
        check({tag, "/lane_valid"}, 128'(bus.o_lane_valid), 128'(e.lv));
        check({tag, "/pc"}, 128'(bus.o_pc), 128'(e.pc));
        check({tag, "/cf_found"}, 128'(bus.o_cf_found), 128'(e.found));
        check({tag, "/cf_lane"}, 128'(bus.o_cf_lane), 128'(e.lane));
        check({tag, "/class"}, 128'({bus.o_isbranch, bus.o_j_inst, bus.o_jal_inst, bus.o_jr_inst}),
              128'(e.cls));
        check({tag, "/branch_address"}, 128'(bus.o_branch_address), 128'(e.baddr));
        check({tag, "/target"}, 128'(bus.o_Branch_Target), 128'(e.tgt));
        check({tag, "/delay_slot"}, 128'(bus.o_delay_slot), 128'(e.ds));
        check({tag, "/ds_head"}, 128'(bus.o_ds_head), 128'(e.dsh));
    endtask

    function automatic exp_t mke(input logic [127:0] insts, input logic [3:0] lv, input logic [21:0] pc,
                                 input logic found, input logic [1:0] lane, input logic [3:0] cls,
                                 input logic [21:0] baddr, input logic [21:0] tgt,
                                 input logic ds, input logic dsh);
        exp_t e;
        e.insts = insts; e.lv = lv; e.pc = pc; e.found = found; e.lane = lane; e.cls = cls;
        e.baddr = baddr; e.tgt = tgt; e.ds = ds; e.dsh = dsh;
        return e;
    endfunction

    // 0 none, 1 branch, 2 j, 3 jal, 4 jr, 5 jalr
    function automatic int kind(input logic [31:0] x);
        int op;
        int fn;
        op = int'(x[31:26]);
        fn = int'(x[5:0]);
        if (op == 1 || (op >= 4 && op <= 7)) return 1;
        if (op == 2) return 2;
        if (op == 3) return 3;
        if (op == 0 && fn == 8) return 4;
        if (op == 0 && fn == 9 && JALR_EN) return 5;
        return 0;
    endfunction

    function automatic exp_t model(input logic [21:0] pc, input logic [127:0] b, input bit ds_in);
        exp_t        e;
        int          ofs, n, cf, keep;
        longint      mask, ba, t;
        logic [31:0] ins;
        e = '0;
        mask = (64'd1 << AW) - 1;
        ofs = int'(pc) % FW;
        n = FW - ofs;
        cf = -1;
        for (int i = (ds_in ? 1 : 0); i < n; i++)
            if (cf < 0 && kind(b[32*(i+ofs) +: 32]) != 0) cf = i;
        keep = (cf >= 0 && cf + 1 < n) ? cf + 2 : n;
        for (int i = 0; i < keep; i++) begin
            e.lv[i] = 1'b1;
            e.insts[32*i +: 32] = b[32*(i+ofs) +: 32];
        end
        e.pc = pc;
        e.dsh = ds_in;
        ba = (longint'(pc) + (cf < 0 ? 0 : cf)) & mask;
        e.baddr = 22'(ba);
        if (cf >= 0) begin
            ins = b[32*(cf+ofs) +: 32];
            e.found = 1'b1;
            e.lane = 2'(cf);
            e.ds = (cf == n - 1);
            case (kind(ins))
                1: begin
                    e.cls = 4'b1000;
                    t = (ba + 1 + longint'($signed(ins[15:0]))) & mask;
                    e.tgt = 22'(t);
                end
                2: begin e.cls = 4'b0100; e.tgt = ins[21:0]; end
                3: begin e.cls = 4'b0010; e.tgt = ins[21:0]; end
                4: e.cls = 4'b0001;
                default: e.cls = 4'b0011;
            endcase
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: case ($urandom_range(0, 4))
                   0: r[31:26] = 6'b000001;
                   1: r[31:26] = 6'b000100;
                   2: r[31:26] = 6'b000101;
                   3: r[31:26] = 6'b000110;
                   default: r[31:26] = 6'b000111;
               endcase
            1: r[31:26] = 6'b000010;
            2: r[31:26] = 6'b000011;
            3: begin r[31:26] = 6'b000000; r[5:0] = 6'b001000; end
            4: begin r[31:26] = 6'b000000; r[5:0] = 6'b001001; end
            5: r[31:26] = 6'b000000;
            default: ;
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t     vecs[$];
    exp_t     q[$];
    exp_t     e_tmp;
    bit       ds_m;
    bit       hold;
    logic [127:0] bj;

    initial begin
        bus.i_valid = 1'b0; bus.i_pc = '0; bus.i_bundle = '0; bus.i_flush = 1'b0; bus.i_ready = 1'b0;

        // Reset state
        #12;
        check("reset/o_valid", 128'(bus.o_valid), 128'd0);
        check("reset/o_ready", 128'(bus.o_ready), 128'd1);
        check("reset/o_insts", bus.o_insts, 128'd0);
        check("reset/o_pc", 128'(bus.o_pc), 128'd0);
        check("reset/o_target", 128'(bus.o_Branch_Target), 128'd0);
        check("reset/o_ds", 128'({bus.o_delay_slot, bus.o_ds_head, bus.o_cf_found}), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        vecs.push_back('{22'h100, {NOP, 32'h1000FFFE, NOP, NOP},
            mke({NOP, 32'h1000FFFE, NOP, NOP}, 4'b1111, 22'h100, 1, 2, 4'b1000, 22'h102, 22'h101, 0, 0)});
        vecs.push_back('{22'h005, {32'h0C000040, 32'h20020002, 32'h20030003, NOP},
            mke({32'h0, 32'h0C000040, 32'h20020002, 32'h20030003}, 4'b0111, 22'h005, 1, 2, 4'b0010,
                22'h007, 22'h040, 1, 0)});
        vecs.push_back('{22'h008, {NOP, 32'h10000003, NOP, 32'h08000123},
            mke({NOP, 32'h10000003, NOP, 32'h08000123}, 4'b1111, 22'h008, 1, 2, 4'b1000,
                22'h00A, 22'h00E, 0, 1)});
        vecs.push_back('{22'h200, {32'h08000077, NOP, NOP, 32'h03E00008},
            mke({32'h0, 32'h0, NOP, 32'h03E00008}, 4'b0011, 22'h200, 1, 0, 4'b0001, 22'h200, 22'h0, 0, 0)});
        vecs.push_back('{22'h3FFFFE, {32'h20050005, 32'h20040004, NOP, NOP},
            mke({64'h0, 32'h20050005, 32'h20040004}, 4'b0011, 22'h3FFFFE, 0, 0, 4'b0000,
                22'h3FFFFE, 22'h0, 0, 0)});
        vecs.push_back('{22'h3FFFFD, {NOP, NOP, 32'h10000005, NOP},
            mke({64'h0, NOP, 32'h10000005}, 4'b0011, 22'h3FFFFD, 1, 0, 4'b1000,
                22'h3FFFFD, 22'h000003, 0, 0)});
        if (JALR_EN)
            vecs.push_back('{22'h300, {NOP, NOP, 32'h00400009, NOP},
                mke({32'h0, NOP, 32'h00400009, NOP}, 4'b0111, 22'h300, 1, 1, 4'b0011, 22'h301, 22'h0, 0, 0)});
        else
            vecs.push_back('{22'h300, {NOP, NOP, 32'h00400009, NOP},
                mke({NOP, NOP, 32'h00400009, NOP}, 4'b1111, 22'h300, 0, 0, 4'b0000, 22'h300, 22'h0, 0, 0)});
        vecs.push_back('{22'h400, {32'h14000010, NOP, NOP, NOP},
            mke({32'h14000010, NOP, NOP, NOP}, 4'b1111, 22'h400, 1, 3, 4'b1000, 22'h403, 22'h414, 1, 0)});

        // Back-to-back accepts: each push coincides with the pop of the previous head
        bus.i_ready = 1'b1;
        foreach (vecs[i]) begin
            bus.i_valid = 1'b1; bus.i_pc = vecs[i].pc; bus.i_bundle = vecs[i].bundle;
            tick();
            bus.i_valid = 1'b0;
            check_head($sformatf("vec%0d", i), vecs[i].e);
        end

        // Flush with pending delay slot and a simultaneous valid input
        bus.i_ready = 1'b0;
        bus.i_valid = 1'b1; bus.i_flush = 1'b1; bus.i_pc = 22'h123; bus.i_bundle = {4{NOP}};
        tick();
        bus.i_valid = 1'b0; bus.i_flush = 1'b0;
        check("flush/o_valid", 128'(bus.o_valid), 128'd0);
        check("flush/o_ready", 128'(bus.o_ready), 128'd1);
        bus.i_valid = 1'b1; bus.i_pc = 22'h500; bus.i_bundle = {NOP, NOP, NOP, 32'h08000ABC};
        tick();
        bus.i_valid = 1'b0;
        check_head("post_flush", mke({64'h0, NOP, 32'h08000ABC}, 4'b0011, 22'h500, 1, 0, 4'b0100,
                                     22'h500, 22'h000ABC, 0, 0));
        bus.i_ready = 1'b1;
        tick();
        check("drain/o_valid", 128'(bus.o_valid), 128'd0);

        // Backpressure: third bundle waits for a pop, order preserved
        bus.i_ready = 1'b0; bus.i_bundle = {4{NOP}};
        bus.i_valid = 1'b1; bus.i_pc = 22'h010; tick();
        check("bp/ready_after_1", 128'(bus.o_ready), 128'd1);
        bus.i_pc = 22'h020; tick();
        check("bp/ready_after_2", 128'(bus.o_ready), 128'd0);
        bus.i_pc = 22'h030; tick();
        check("bp/ready_held", 128'(bus.o_ready), 128'd0);
        check("bp/head_A", 128'(bus.o_pc), 128'h010);
        bus.i_ready = 1'b1; tick();
        check("bp/head_B", 128'(bus.o_pc), 128'h020);
        check("bp/ready_after_pop", 128'(bus.o_ready), 128'd1);
        bus.i_ready = 1'b0; tick();
        bus.i_valid = 1'b0;
        check("bp/ready_C_in", 128'(bus.o_ready), 128'd0);
        check("bp/head_B_still", 128'(bus.o_pc), 128'h020);
        bus.i_ready = 1'b1; tick();
        check("bp/head_C", 128'(bus.o_pc), 128'h030);
        tick();
        check("bp/empty", 128'(bus.o_valid), 128'd0);

        // Asynchronous reset mid-operation
        bus.i_ready = 1'b0; bus.i_valid = 1'b1; bus.i_pc = 22'h040; tick();
        bus.i_valid = 1'b0;
        check("areset/pre_valid", 128'(bus.o_valid), 128'd1);
        #2 rst_n = 1'b0;
        #1;
        check("areset/o_valid", 128'(bus.o_valid), 128'd0);
        check("areset/o_pc", 128'(bus.o_pc), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Randomized traffic against the reference model
        ds_m = 1'b0;
        hold = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (!hold) begin
                bus.i_valid = ($urandom_range(0, 3) != 0);
                bus.i_pc = 22'($urandom);
                for (int l = 0; l < FW; l++) bj[32*l +: 32] = rand_inst();
                bus.i_bundle = bj;
            end
            bus.i_flush = ($urandom_range(0, 40) == 0);
            bus.i_ready = ($urandom_range(0, 2) != 0);
            #3;
            check("rnd/o_valid", 128'(bus.o_valid), 128'(q.size() != 0));
            check("rnd/o_ready", 128'(bus.o_ready), 128'(q.size() < 2));
            if (bus.i_ready && q.size() != 0) check_head("rnd", q[0]);
            hold = 1'b0;
            if (bus.i_flush) begin
                q.delete();
                ds_m = 1'b0;
            end else begin
                hold = bus.i_valid && (q.size() >= 2);
                if (bus.i_valid && q.size() < 2) begin
                    e_tmp = model(bus.i_pc, bus.i_bundle, ds_m);
                    ds_m = e_tmp.ds;
                    if (bus.i_ready && q.size() != 0) void'(q.pop_front());
                    q.push_back(e_tmp);
                end else if (bus.i_ready && q.size() != 0) begin
                    void'(q.pop_front());
                end
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/predecode_aligner.md
Name: predecode_aligner

Overview:
- Registered, parametrised successor to the fetch pre-decode/align stage; sits between I_CACHE and the branch predictor, fetch unit and jump stack.
- Accepts a FETCH_WIDTH-instruction bundle plus PC, rotates it so lane 0 holds the instruction at i_pc, and finds the first control-flow (CF) instruction.
- Computes the CF target, masks lanes after the delay slot, and tracks a delay slot that spills into the next bundle.
- Output is buffered behind a 2-entry skid FIFO with a valid/ready handshake.

Parameters:
- ADDRESS_WIDTH, 22, word-address width (2..26).
- DATA_WIDTH, 32, instruction width (fixed MIPS encoding; must be 32).
- FETCH_WIDTH, 4, instructions per bundle; power of 2, 2..8.
- OFS_W, log2(FETCH_WIDTH), derived; lane-offset width taken from i_pc[OFS_W-1:0].

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  bundle valid from I_CACHE
- o_ready  out  1  block can accept; high when FIFO count < 2
- i_pc  in  ADDRESS_WIDTH  word address of the first wanted instruction
- i_bundle  in  FETCH_WIDTH*DATA_WIDTH  cache-line instructions; lane k at bits [k*32+31:k*32]
- i_flush  in  1  redirect; discards buffered and pending state
- o_valid  out  1  head entry valid
- i_ready  in  1  downstream accepts the head entry
- o_insts  out  FETCH_WIDTH*DATA_WIDTH  aligned instructions; invalid lanes are 0
- o_lane_valid  out  FETCH_WIDTH  per-lane valid mask
- o_pc  out  ADDRESS_WIDTH  PC of aligned lane 0
- o_cf_found  out  1  a CF instruction was found in a valid lane
- o_cf_lane  out  OFS_W  aligned lane index of that CF instruction
- o_isbranch  out  1  CF is a conditional branch
- o_j_inst, o_jal_inst, o_jr_inst  out  1 each  CF class (one-hot with o_isbranch when o_cf_found)
- o_branch_address  out  ADDRESS_WIDTH  o_pc + o_cf_lane
- o_Branch_Target  out  ADDRESS_WIDTH  computed target (0 for jr)
- o_delay_slot  out  1  the delay slot falls in the next bundle
- o_ds_head  out  1  aligned lane 0 is the delay slot of the previous bundle's CF

Behaviour:
- Reset (async, active-low): FIFO empty, ds_pend=0. All outputs 0 except o_ready=1.
- Accept when i_valid && o_ready && !i_flush. The entry appears at the head 1 cycle later (o_valid rises on the next edge if the FIFO was empty).
- Pop when o_valid && i_ready. Push and pop in the same cycle keep the count unchanged. The FIFO preserves order.
- Decode on opcode op=inst[31:26]:
  - branch: op in {000001, 000100, 000101, 000110, 000111}
  - j: op=000010
  - jal: op=000011
  - jr: op=000000 and funct inst[5:0]=001000
- Alignment: ofs=i_pc[OFS_W-1:0]. Aligned lane k = input lane k+ofs for k < FETCH_WIDTH-ofs; other lanes are invalid.
- Scan: the lowest valid aligned lane with a CF wins. If ds_pend=1 at accept, lane 0 is excluded from the scan (a CF in a delay slot is ignored) and o_ds_head=1.
- Lane mask:
  - If CF at lane c and c+1 is valid: lanes > c+1 are cleared and o_delay_slot=0.
  - If c is the last valid lane: o_delay_slot=1 and ds_pend is set.
  - Otherwise ds_pend is cleared on accept.
- Targets (mod 2^ADDRESS_WIDTH):
  - branch: o_branch_address + 1 + sign-extended inst[15:0]
  - j/jal: zero-extended inst[ADDRESS_WIDTH-1:0]
  - jr: 0
- No CF: o_cf_found=0, class flags 0, o_cf_lane=0, o_Branch_Target=0, o_branch_address=o_pc.
- Full FIFO: o_ready=0; i_valid is ignored and the input must be held.
- i_flush: FIFO cleared and ds_pend=0 on the next edge. Flush wins over a simultaneous accept (input dropped) and over a pop.
- Reset mid-operation drops all entries immediately.
- PC wrap: i_pc + lane wraps modulo 2^ADDRESS_WIDTH.

Optional Feature:
- PREDECODE_JALR_EN defined: op=000000 with funct=001001 (jalr) is a CF. It sets both o_jr_inst and o_jal_inst (indirect + link).
- Undefined: jalr is not CF and lanes are not truncated.

Test Plan:
- ofs=0, lane2 = 0x1000FFFE (beq, imm=-2), pc=0x100 -> lane_valid=0b1111, cf_lane=2, branch_address=0x102, target=0x101, delay_slot=0.
- ofs=1, pc=0x0005, lane3 = 0x0C000040 (jal) -> aligned lane 2, lane_valid=0b0111, jal=1, target=0x40, delay_slot=1. Next accepted bundle has ds_head=1 and a j in its lane 0 is ignored.
- ofs=0, jr (0x03E00008) in lane 0, j in lane 3 -> cf_lane=0, jr=1, target=0, lane_valid=0b0011.
- Hold i_ready=0 and push 3 bundles -> o_ready falls after the 2nd; the 3rd is accepted only after a pop; order is preserved.
- i_flush with i_valid high and ds_pend=1 -> o_valid=0 next cycle, ds_pend=0, input dropped. Next bundle has ds_head=0.
- With PREDECODE_JALR_EN, 0x00400009 in lane 1 -> jr=1, jal=1, cf_lane=1. Without the macro -> cf_found=0.
